// File: rtl/store_queue_fwd_if.sv
// Store queue bus bundle: memory-stage enqueue, load-forward lookup, cache drain, status.
// Latency: none (wiring only).
// Backpressure: enq_ready and drain_ready carry flow control in opposite directions.
//
// slave  : the store queue itself.
// master : the environment (memory stage + L1 data cache side).
interface store_queue_fwd_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // enqueue from the memory stage
  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [BYTES-1:0]  enq_mask;

  // store-to-load forwarding lookup
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [BYTES-1:0]  ld_mask;
  logic              ld_fwd_hit;
  logic              ld_fwd_partial;
  logic [DATA_W-1:0] ld_fwd_data;

  // drain to the L1 data cache
  logic              drain_valid;
  logic              drain_ready;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic [BYTES-1:0]  drain_mask;

  // status
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_mask,
    input  ld_valid, ld_addr, ld_mask,
    input  drain_ready,
    output enq_ready,
    output ld_fwd_hit, ld_fwd_partial, ld_fwd_data,
    output drain_valid, drain_addr, drain_data, drain_mask,
    output count, empty
  );

  modport master (
    output enq_valid, enq_addr, enq_data, enq_mask,
    output ld_valid, ld_addr, ld_mask,
    output drain_ready,
    input  enq_ready,
    input  ld_fwd_hit, ld_fwd_partial, ld_fwd_data,
    input  drain_valid, drain_addr, drain_data, drain_mask,
    input  count, empty
  );
endinterface

// File: rtl/store_queue_fwd.sv
// Store queue: buffers committed stores, drains them in order to L1, forwards bytes to loads.
// Latency: enqueue visible to drain/forward/count one cycle after acceptance; forwarding is combinational.
// Backpressure: enq_ready = !full only (no path from drain_ready); drain_* held stable while stalled.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - store_queue_fwd_if.slave: enq_* (store in), ld_* (forward lookup),
//          drain_* (to cache), count/empty (status)
module store_queue_fwd #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int COALESCE = 1
) (
  input  logic             clk,
  input  logic             rst,
  store_queue_fwd_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  // Clears the byte-offset bits so entries and compares work on word addresses.
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << OFF_W;

  // Pointer state: index plus one wrap bit.
  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_tail;
  logic [IDX_W:0]    r_count;
  logic              r_empty;

  // Entry storage (not reset; validity comes from the pointers).
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BYTES-1:0]  r_mask [DEPTH];

  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_tail_idx;
  logic [IDX_W-1:0]  w_last_idx;
  logic              w_full;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_coalesce;
  logic              w_push;
  logic              w_merge;
  logic [ADDR_W-1:0] w_enq_word;
  logic [ADDR_W-1:0] w_ld_word;
  logic [IDX_W:0]    w_count_nxt;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_last_idx = w_tail_idx - 1'b1;

  assign w_full = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                  (r_head[IDX_W] != r_tail[IDX_W]);

  assign w_enq_word = bus.enq_addr & WORD_MASK;
  assign w_ld_word  = bus.ld_addr & WORD_MASK;

  assign w_enq_fire = bus.enq_valid && !w_full;
  assign w_deq_fire = !r_empty && bus.drain_ready;

  // Merge only into the youngest entry, and only when at least two entries are
  // live so that entry is never the head (the head may be mid-handshake).
  assign w_coalesce = (COALESCE != 0) &&
                      (r_count >= (IDX_W+1)'(2)) &&
                      (r_addr[w_last_idx] == w_enq_word);

  assign w_push  = w_enq_fire && !w_coalesce;
  assign w_merge = w_enq_fire && w_coalesce;

  assign w_count_nxt = r_count
                     + {{IDX_W{1'b0}}, w_push}
                     - {{IDX_W{1'b0}}, w_deq_fire};

  // ------------------------------------------------------------------
  // Pointer / occupancy state
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + (IDX_W+1)'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + (IDX_W+1)'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // ------------------------------------------------------------------
  // Entry storage writes
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[w_tail_idx] <= w_enq_word;
      r_data[w_tail_idx] <= bus.enq_data;
      r_mask[w_tail_idx] <= bus.enq_mask;
    end else if (w_merge) begin
      r_mask[w_last_idx] <= r_mask[w_last_idx] | bus.enq_mask;
      for (int b = 0; b < BYTES; b++) begin
        if (bus.enq_mask[b]) begin
          r_data[w_last_idx][8*b +: 8] <= bus.enq_data[8*b +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Enqueue / drain outputs
  // ------------------------------------------------------------------
  assign bus.enq_ready   = !w_full;
  assign bus.drain_valid = !r_empty;
  // Head entry straight from storage; forced to zero while nothing is queued
  // so stale array contents never appear on the cache bus.
  assign bus.drain_addr  = r_empty ? '0 : r_addr[w_head_idx];
  assign bus.drain_data  = r_empty ? '0 : r_data[w_head_idx];
  assign bus.drain_mask  = r_empty ? '0 : r_mask[w_head_idx];
  assign bus.count       = r_count;
  assign bus.empty       = r_empty;

  // ------------------------------------------------------------------
  // Store-to-load forwarding
  // Scanning oldest to youngest and letting later matches overwrite earlier
  // ones selects, per lane, the youngest covering entry. Only registered state
  // is consulted, so a same-cycle enqueue is invisible and a draining head is
  // still visible.
  // ------------------------------------------------------------------
  logic [IDX_W-1:0]  w_scan_idx;
  logic [BYTES-1:0]  w_fwd_cov;
  logic [DATA_W-1:0] w_fwd_data;

  always_comb begin
    w_scan_idx = '0;
    w_fwd_cov  = '0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = w_head_idx + IDX_W'(k);
      if (((IDX_W+1)'(k) < r_count) && (r_addr[w_scan_idx] == w_ld_word)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.ld_mask[b] && r_mask[w_scan_idx][b]) begin
            w_fwd_cov[b]          = 1'b1;
            w_fwd_data[8*b +: 8]  = r_data[w_scan_idx][8*b +: 8];
          end
        end
      end
    end
  end

  // w_fwd_cov only contains requested lanes, so full coverage is equality.
  assign bus.ld_fwd_hit     = bus.ld_valid && (bus.ld_mask != '0) &&
                              (w_fwd_cov == bus.ld_mask);
  assign bus.ld_fwd_partial = bus.ld_valid && (w_fwd_cov != '0) &&
                              (w_fwd_cov != bus.ld_mask);
  assign bus.ld_fwd_data    = bus.ld_valid ? w_fwd_data : '0;

endmodule

// File: tb/tb_store_queue_fwd.sv
// Self-checking bench for store_queue_fwd (DEPTH=4, 32-bit address/data, COALESCE=1).
module tb_store_queue_fwd;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_queue_fwd_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sq ();

  store_queue_fwd #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COALESCE(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sq.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        valid;
    logic        hit;
    logic        part;
    logic [31:0] data;
    bit          chk_data;
  } fvec_t;

  ent_t model[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every DUT status/drain output against the reference queue.
  task automatic model_chk();
    chk("count", 32'(sq.count), 32'(model.size()));
    chk("empty", 32'(sq.empty), 32'(model.size() == 0));
    chk("enq_ready", 32'(sq.enq_ready), 32'(model.size() < DEPTH));
    chk("drain_valid", 32'(sq.drain_valid), 32'(model.size() != 0));
    if (model.size() != 0) begin
      chk("drain_addr", sq.drain_addr, model[0].addr);
      chk("drain_data", sq.drain_data, model[0].data);
      chk("drain_mask", 32'(sq.drain_mask), 32'(model[0].mask));
    end else begin
      chk("drain_addr_idle", sq.drain_addr, 32'h0);
      chk("drain_mask_idle", 32'(sq.drain_mask), 32'h0);
    end
  endtask

  // One clock: settle, check against model, apply the handshakes to the model,
  // then move to the next falling edge. acc reports whether the store was taken.
  task automatic cycle(output bit acc);
    bit   deq;
    bit   enq;
    bit   coal;
    ent_t e;
    #1;
    model_chk();
    deq  = (model.size() != 0) && sq.drain_ready;
    enq  = sq.enq_valid && (model.size() < DEPTH);
    coal = 0;
    if (enq && model.size() >= 2 && model[model.size()-1].addr == (sq.enq_addr & 32'hFFFF_FFFC)) begin
      coal = 1;
      e = model[model.size()-1];
      e.mask = e.mask | sq.enq_mask;
      for (int b = 0; b < 4; b++)
        if (sq.enq_mask[b]) e.data[8*b +: 8] = sq.enq_data[8*b +: 8];
      model[model.size()-1] = e;
    end
    if (deq) void'(model.pop_front());
    if (enq && !coal) begin
      e.addr = sq.enq_addr & 32'hFFFF_FFFC;
      e.data = sq.enq_data;
      e.mask = sq.enq_mask;
      model.push_back(e);
    end
    acc = enq;
    @(negedge clk);
  endtask

  task automatic tick();
    bit acc;
    cycle(acc);
  endtask

  task automatic set_enq(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    sq.enq_valid = v;
    sq.enq_addr  = a;
    sq.enq_data  = d;
    sq.enq_mask  = m;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    set_enq(1'b1, a, d, m);
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic fwd_chk(input string name, input logic [31:0] a, input logic [3:0] m, input logic v,
                         input logic eh, input logic ep, input logic [31:0] ed, input bit cd);
    sq.ld_valid = v;
    sq.ld_addr  = a;
    sq.ld_mask  = m;
    #1;
    chk({name, ".hit"}, 32'(sq.ld_fwd_hit), 32'(eh));
    chk({name, ".partial"}, 32'(sq.ld_fwd_partial), 32'(ep));
    if (cd) chk({name, ".data"}, sq.ld_fwd_data, ed);
    sq.ld_valid = 1'b0;
  endtask

  task automatic drain_all();
    int budget;
    budget = 0;
    sq.drain_ready = 1'b1;
    while (model.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    chk("drain_all_timeout", 32'(model.size()), 32'h0);
    sq.drain_ready = 1'b0;
  endtask

  fvec_t fv[10];

  initial begin
    bit acc;
    int got;
    int budget;

    set_enq(1'b0, 32'h0, 32'h0, 4'h0);
    sq.ld_valid    = 1'b0;
    sq.ld_addr     = '0;
    sq.ld_mask     = '0;
    sq.drain_ready = 1'b0;
    rst            = 1'b0;

    // ---------------- reset values ----------------
    @(negedge clk);
    fwd_chk("reset_fwd", 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    chk("reset_enq_ready", 32'(sq.enq_ready), 32'h1);
    chk("reset_drain_valid", 32'(sq.drain_valid), 32'h0);
    chk("reset_count", 32'(sq.count), 32'h0);
    chk("reset_empty", 32'(sq.empty), 32'h1);
    chk("reset_drain_data", sq.drain_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // ---------------- fill then ordered drain ----------------
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF);
    #1;
    chk("fill_count", 32'(sq.count), 32'h4);
    chk("fill_enq_ready", 32'(sq.enq_ready), 32'h0);
    chk("fill_drain_addr", sq.drain_addr, 32'h100);
    sq.drain_ready = 1'b1;
    repeat (4) tick();
    sq.drain_ready = 1'b0;
    #1;
    chk("fill_drained_empty", 32'(sq.empty), 32'h1);

    // ---------------- coalescing ----------------
    push(32'h200, 32'h0000_00AA, 4'h1);
    push(32'h300, 32'h0000_0011, 4'h1);
    push(32'h300, 32'h0000_BB00, 4'h2);
    #1;
    chk("coal_count", 32'(sq.count), 32'h2);
    fwd_chk("coal_merged", 32'h300, 4'h3, 1'b1, 1'b1, 1'b0, 32'h0000_BB11, 1);
    push(32'h200, 32'h00CC_0000, 4'h4);
    #1;
    chk("coal_head_addr_new_entry", 32'(sq.count), 32'h3);
    drain_all();
    // tail-1 is the head when only one entry is live: must not merge
    push(32'h500, 32'h0000_0001, 4'h1);
    push(32'h500, 32'h0000_0200, 4'h2);
    #1;
    chk("coal_head_protect", 32'(sq.count), 32'h2);
    drain_all();

    // ---------------- forwarding table ----------------
    push(32'h400, 32'h0000_1122, 4'h3);
    push(32'h400, 32'h0000_0033, 4'h1);
    push(32'h404, 32'hDEAD_BEEF, 4'hF);
    push(32'h400, 32'h7700_0000, 4'h8);
    fv[0] = '{32'h400, 4'h3, 1'b1, 1'b1, 1'b0, 32'h0000_1133, 1};
    fv[1] = '{32'h400, 4'hF, 1'b1, 1'b0, 1'b1, 32'h7700_1133, 1};
    fv[2] = '{32'h400, 4'h4, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1};
    fv[3] = '{32'h402, 4'h3, 1'b1, 1'b1, 1'b0, 32'h0000_1133, 1};
    fv[4] = '{32'h404, 4'hF, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1};
    fv[5] = '{32'h404, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1};
    fv[6] = '{32'h408, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1};
    fv[7] = '{32'h400, 4'h8, 1'b1, 1'b1, 1'b0, 32'h7700_0000, 1};
    fv[8] = '{32'h404, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 0};
    fv[9] = '{32'h404, 4'h6, 1'b1, 1'b1, 1'b0, 32'h00AD_BE00, 1};
    for (int i = 0; i < 10; i++)
      fwd_chk($sformatf("fwd_vec%0d", i), fv[i].addr, fv[i].mask, fv[i].valid,
              fv[i].hit, fv[i].part, fv[i].data, fv[i].chk_data);

    // draining head still visible this cycle, gone after
    sq.drain_ready = 1'b1;
    fwd_chk("fwd_draining_visible", 32'h400, 4'h2, 1'b1, 1'b1, 1'b0, 32'h0000_1100, 1);
    tick();
    sq.drain_ready = 1'b0;
    fwd_chk("fwd_drained_gone", 32'h400, 4'h2, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    // same-cycle enqueue invisible, visible next cycle
    set_enq(1'b1, 32'h600, 32'h600D_0000, 4'hF);
    fwd_chk("fwd_same_cycle_enq", 32'h600, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 4'h0);
    fwd_chk("fwd_next_cycle_enq", 32'h600, 4'hF, 1'b1, 1'b1, 1'b0, 32'h600D_0000, 1);
    drain_all();

    // ---------------- full-rate streaming across pointer wraps ----------------
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4*i), 32'h5000_0000 + 32'(i), 4'hF);
    sq.drain_ready = 1'b1;
    got = 0;
    budget = 0;
    while (got < 14 && budget < 40) begin
      set_enq(1'b1, 32'h1000 + 32'(4*(4+got)), 32'h5000_0000 + 32'(4+got), 4'hF);
      if (budget == 1) chk("stream_enq_ready_after_full", 32'(sq.enq_ready), 32'h1);
      cycle(acc);
      if (acc) got++;
      budget++;
    end
    chk("stream_accepted", 32'(got), 32'd14);
    set_enq(1'b0, 32'h0, 32'h0, 4'h0);
    drain_all();

    // ---------------- random backpressure ----------------
    for (int i = 0; i < 50; i++) begin
      set_enq(1'b1, 32'h2000 + 32'(4*$urandom_range(0, 2)), $urandom, 4'($urandom_range(1, 15)));
      acc = 0;
      budget = 0;
      while (!acc && budget < 100) begin
        sq.drain_ready = 1'($urandom_range(0, 1));
        cycle(acc);
        budget++;
      end
      if (!acc) chk($sformatf("rand_store%0d_timeout", i), 32'h0, 32'h1);
    end
    set_enq(1'b0, 32'h0, 32'h0, 4'h0);
    drain_all();

    // ---------------- reset while a drain is stalled ----------------
    for (int i = 0; i < 3; i++) push(32'h800 + 32'(4*i), 32'h8000_0000 + 32'(i), 4'hF);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_drain_valid", 32'(sq.drain_valid), 32'h0);
    chk("arst_count", 32'(sq.count), 32'h0);
    chk("arst_empty", 32'(sq.empty), 32'h1);
    model.delete();
    @(negedge clk);
    rst = 1'b1;
    push(32'h700, 32'h7777_0007, 4'hF);
    #1;
    chk("arst_first_after", sq.drain_addr, 32'h700);
    chk("arst_first_data", sq.drain_data, 32'h7777_0007);
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
- Parametrised successor to the core's fixed single-purpose store queue; sits between the memory stage and the L1 data cache.
- Buffers committed stores in a DEPTH-entry circular FIFO and drains them in order to the cache through a valid/ready handshake.
- Optionally coalesces back-to-back stores to the same word.
- Provides combinational per-byte store-to-load forwarding so the memory stage can complete loads without waiting for the drain.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- ADDR_W, 32, byte address width; entries hold word-aligned addresses.
- DATA_W, 32, word width in bits; multiple of 8; BYTES = DATA_W/8.
- COALESCE, 1, 1 = merge an enqueue into the youngest entry when the word address matches; 0 = never merge.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- enq_valid  in  1  memory stage presents a committed store.
- enq_ready  out  1  queue can accept; equals !full.
- enq_addr  in  ADDR_W  store address; low log2(BYTES) bits ignored.
- enq_data  in  DATA_W  lane-aligned store data.
- enq_mask  in  BYTES  byte enables.
- ld_valid  in  1  load lookup request.
- ld_addr  in  ADDR_W  load address; word-aligned compare.
- ld_mask  in  BYTES  requested bytes.
- ld_fwd_hit  out  1  every requested byte is supplied by the queue.
- ld_fwd_partial  out  1  some, but not all, requested bytes match; the load must stall.
- ld_fwd_data  out  DATA_W  forwarded bytes; lanes without a match are 0.
- drain_valid  out  1  head entry is offered to the cache.
- drain_ready  in  1  cache accepts the head entry.
- drain_addr  out  ADDR_W  head word address, low bits 0.
- drain_data  out  DATA_W  head data.
- drain_mask  out  BYTES  head byte enables.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count == 0; used by fences.

Behaviour:
- Storage: head and tail pointers, each log2(DEPTH) bits plus a wrap bit. full = (index equal and wrap bits differ). empty = (pointers equal).
- Reset (rst low, async): head = tail = 0. All valid state cleared. Outputs: enq_ready=1, drain_valid=0, count=0, empty=1, ld_fwd_hit=0, ld_fwd_partial=0, ld_fwd_data=0. drain_addr, drain_data and drain_mask read 0 while empty. Data arrays are not reset. Reset mid-drain discards all entries; recovery is the system's responsibility.
- Enqueue: occurs when enq_valid && enq_ready.
  - Coalesce when COALESCE=1 && count>=2 && enq word address == word address of entry tail-1. The entry must not be the head, because the head may be mid-handshake. On coalesce, bytes with enq_mask set overwrite that entry's data, its mask |= enq_mask, and tail does not advance.
  - Otherwise write entry[tail] and advance tail, wrapping at DEPTH.
- enq_ready depends only on full. It never depends on drain_ready, so no combinational path runs from the cache to the memory stage. When full, a coalescible store also waits.
- Drain: drain_valid = !empty. drain_* are driven directly from the registers of entry[head]. On drain_valid && drain_ready, head advances. drain_* must stay stable while drain_valid && !drain_ready.
- Simultaneous enqueue and drain in the same cycle: count is unchanged (for a non-coalescing enqueue). This is legal at any occupancy except full, where enq_ready=0.
- Forwarding (combinational, current registered state only):
  - A same-cycle enqueue is not visible. An entry draining this cycle is still visible.
  - For each byte lane b with ld_mask[b]=1, pick the youngest valid entry with matching word address and mask[b]=1, scanning from tail-1 down to head with wrap.
  - ld_fwd_hit = ld_valid && every requested lane is covered.
  - ld_fwd_partial = ld_valid && at least one lane is covered && not all lanes are covered.
  - ld_mask=0 gives hit=0 and partial=0.
  - Different lanes may come from different entries.
- count updates on the cycle after the event. count and empty are registered.

Test Plan:
- Reset, then enqueue 4 stores to 0x100/0x104/0x108/0x10C (mask 0xF, DEPTH=4, drain_ready=0) -> count=4, enq_ready=0, drain_addr=0x100. Release drain_ready for 4 cycles -> data drains in order, then empty=1.
- COALESCE=1: enqueue 0x200 mask 0x1 data 0xAA, then 0x300, then 0x300 mask 0x2 data 0xBB00 -> count=2, entry 0x300 has mask 0x3. A second store to 0x200 while 0x200 is the head -> new entry, count=3.
- Forwarding: queue holds 0x400 mask 0x3 data 0x1122 (older) and 0x400 mask 0x1 data 0x33 (younger). Load 0x400 mask 0x3 -> hit=1, data=0x0000_1133. Load mask 0xF -> partial=1, hit=0.
- Full queue with drain_ready=1 and enq_valid=1 -> one drain per cycle. enq_ready=0 on the cycle the queue is full, then 1 on the next. No entry is lost or duplicated across 3 pointer wraps.
- Backpressure: drain_ready toggles randomly over 50 stores -> drain_* are stable while stalled, and cache-side order and content match a scoreboard model.
- Assert rst low while count=3 and a drain is stalled -> drain_valid falls to 0 asynchronously and count=0. After release, the next enqueue drains first.
